// File: rtl/jzjpcc_pkg.sv
// jzjpcc_pkg: shared encodings for the execute stage (ALU ops, operand mux, branch funct3).
// Revision 1.0
`default_nettype none

package jzjpcc_pkg;

  typedef enum logic [1:0] {
    MUX_RS1_RS2  = 2'b00,
    MUX_RS1_IMM  = 2'b01,
    MUX_PC_IMM   = 2'b10,
    MUX_ZERO_IMM = 2'b11
  } operand_mux_e;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SLL  = 3'b001,
    ALU_SLT  = 3'b010,
    ALU_SLTU = 3'b011,
    ALU_XOR  = 3'b100,
    ALU_SR   = 3'b101,
    ALU_OR   = 3'b110,
    ALU_AND  = 3'b111
  } alu_op_e;

  localparam logic [2:0] BR_EQ  = 3'b000;
  localparam logic [2:0] BR_NE  = 3'b001;
  localparam logic [2:0] BR_LT  = 3'b100;
  localparam logic [2:0] BR_GE  = 3'b101;
  localparam logic [2:0] BR_LTU = 3'b110;
  localparam logic [2:0] BR_GEU = 3'b111;

  function automatic logic branch_cond(input logic [2:0] funct3,
                                       input logic [31:0] a,
                                       input logic [31:0] b);
    logic r;
    r = 1'b0;
    case (funct3)
      BR_EQ:   r = (a == b);
      BR_NE:   r = (a != b);
      BR_LT:   r = ($signed(a) < $signed(b));
      BR_GE:   r = ($signed(a) >= $signed(b));
      BR_LTU:  r = (a < b);
      BR_GEU:  r = (a >= b);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/jzjpcc_execute_if.sv
// jzjpcc_execute_if: decode-to-execute fields, writeback forwarding, fetch redirect and memory-stage register.
// Revision 1.0
`default_nettype none

interface jzjpcc_execute_if #(
  parameter int PC_MAX_B = 31
);
  logic                rdWriteEnable_execute;
  logic                memoryWriteEnable_execute;
  logic [2:0]          aluOperation_execute;
  logic                aluMod_execute;
  logic [1:0]          aluMuxMode_execute;
  logic                rdSource_execute;
  logic [4:0]          rdAddr_execute;
  logic [2:0]          funct3_execute;
  logic [31:0]         immediate_execute;
  logic [PC_MAX_B:2]   currentPC_execute;
  logic [31:0]         rs1_execute;
  logic [31:0]         rs2_execute;
  logic [4:0]          rs1Addr_execute;
  logic [4:0]          rs2Addr_execute;
  logic                branch_execute;
  logic                jal_execute;
  logic                jalr_execute;
  logic                rdWriteEnable_writeback;
  logic [4:0]          rdAddr_writeback;
  logic [31:0]         rdData_writeback;
  logic                pcCTWriteEnable;
  logic [PC_MAX_B:2]   controlTransferNewPC;
  logic                flush_execute;
  logic                stall_request;
  logic [31:0]         aluResult_memory;
  logic [31:0]         storeData_memory;
  logic [4:0]          rdAddr_memory;
  logic [2:0]          funct3_memory;
  logic                rdSource_memory;
  logic                rdWriteEnable_memory;
  logic                memoryWriteEnable_memory;

  modport slave (
    input  rdWriteEnable_execute, memoryWriteEnable_execute, aluOperation_execute,
           aluMod_execute, aluMuxMode_execute, rdSource_execute, rdAddr_execute,
           funct3_execute, immediate_execute, currentPC_execute, rs1_execute,
           rs2_execute, rs1Addr_execute, rs2Addr_execute, branch_execute,
           jal_execute, jalr_execute, rdWriteEnable_writeback, rdAddr_writeback,
           rdData_writeback,
    output pcCTWriteEnable, controlTransferNewPC, flush_execute, stall_request,
           aluResult_memory, storeData_memory, rdAddr_memory, funct3_memory,
           rdSource_memory, rdWriteEnable_memory, memoryWriteEnable_memory
  );

  modport master (
    output rdWriteEnable_execute, memoryWriteEnable_execute, aluOperation_execute,
           aluMod_execute, aluMuxMode_execute, rdSource_execute, rdAddr_execute,
           funct3_execute, immediate_execute, currentPC_execute, rs1_execute,
           rs2_execute, rs1Addr_execute, rs2Addr_execute, branch_execute,
           jal_execute, jalr_execute, rdWriteEnable_writeback, rdAddr_writeback,
           rdData_writeback,
    input  pcCTWriteEnable, controlTransferNewPC, flush_execute, stall_request,
           aluResult_memory, storeData_memory, rdAddr_memory, funct3_memory,
           rdSource_memory, rdWriteEnable_memory, memoryWriteEnable_memory
  );
endinterface

`default_nettype wire

// File: rtl/jzjpcc_alu.sv
// jzjpcc_alu: combinational 32-bit RV32I ALU; mod selects sub / arithmetic right shift.
// Revision 1.0
`default_nettype none

module jzjpcc_alu
  import jzjpcc_pkg::*;
(
  input  alu_op_e     op,
  input  logic        mod,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result
);

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD:  result = mod ? (a - b) : (a + b);
      ALU_SLL:  result = a << b[4:0];
      ALU_SLT:  result = {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: result = {31'b0, a < b};
      ALU_XOR:  result = a ^ b;
      ALU_SR:   result = mod ? 32'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
      ALU_OR:   result = a | b;
      ALU_AND:  result = a & b;
      default:  result = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/jzjpcc_execute.sv
// jzjpcc_execute: execute stage with forwarding, branch resolution and the execute-to-memory register.
// Revision 1.0
`default_nettype none

module jzjpcc_execute
  import jzjpcc_pkg::*;
#(
  parameter int PC_MAX_B = 31
) (
  input  logic              clock,
  input  logic              reset,
  jzjpcc_execute_if.slave   bus
);

  logic [31:0]       pc_byte;
  logic [31:0]       fwd_rs1;
  logic [31:0]       fwd_rs2;
  logic [31:0]       op_a;
  logic [31:0]       op_b;
  logic [31:0]       alu_result;
  logic [31:0]       target;
  logic [31:0]       link;
  logic              is_jump;
  logic              taken;
  logic              load_use;
  logic              unused_target_bits;

  logic [31:0]       mem_alu;
  logic [31:0]       mem_store;
  logic [4:0]        mem_rd;
  logic [2:0]        mem_funct3;
  logic              mem_src;
  logic              mem_rd_we;
  logic              mem_mem_we;

  assign pc_byte = 32'({bus.currentPC_execute, 2'b00});

  // Memory stage wins over writeback; loads in memory have no data yet and cannot forward.
  always_comb begin
    fwd_rs1 = bus.rs1_execute;
    if (bus.rs1Addr_execute == 5'd0)
      fwd_rs1 = '0;
    else if (mem_rd_we && !mem_src && (mem_rd == bus.rs1Addr_execute))
      fwd_rs1 = mem_alu;
    else if (bus.rdWriteEnable_writeback && (bus.rdAddr_writeback == bus.rs1Addr_execute))
      fwd_rs1 = bus.rdData_writeback;

    fwd_rs2 = bus.rs2_execute;
    if (bus.rs2Addr_execute == 5'd0)
      fwd_rs2 = '0;
    else if (mem_rd_we && !mem_src && (mem_rd == bus.rs2Addr_execute))
      fwd_rs2 = mem_alu;
    else if (bus.rdWriteEnable_writeback && (bus.rdAddr_writeback == bus.rs2Addr_execute))
      fwd_rs2 = bus.rdData_writeback;
  end

  assign load_use = mem_rd_we && mem_src && (mem_rd != 5'd0) &&
                    ((mem_rd == bus.rs1Addr_execute) || (mem_rd == bus.rs2Addr_execute));

  always_comb begin
    op_a = fwd_rs1;
    op_b = bus.immediate_execute;
    case (operand_mux_e'(bus.aluMuxMode_execute))
      MUX_RS1_RS2:  op_b = fwd_rs2;
      MUX_RS1_IMM:  op_a = fwd_rs1;
      MUX_PC_IMM:   op_a = pc_byte;
      MUX_ZERO_IMM: op_a = '0;
      default:      op_a = fwd_rs1;
    endcase
  end

  jzjpcc_alu u_alu (
    .op     (alu_op_e'(bus.aluOperation_execute)),
    .mod    (bus.aluMod_execute),
    .a      (op_a),
    .b      (op_b),
    .result (alu_result)
  );

  assign is_jump = bus.jal_execute | bus.jalr_execute;
  assign taken   = is_jump | (bus.branch_execute &
                   branch_cond(bus.funct3_execute, fwd_rs1, fwd_rs2));
  assign target  = bus.jalr_execute ? ((fwd_rs1 + bus.immediate_execute) & ~32'h1)
                                    : (pc_byte + bus.immediate_execute);
  assign link    = pc_byte + 32'd4;
  assign unused_target_bits = ^target;

  assign bus.controlTransferNewPC = target[PC_MAX_B:2];
  assign bus.stall_request        = !reset && load_use;
  // A stalled transfer replays once the load data is available, so it must not redirect now.
  assign bus.pcCTWriteEnable      = !reset && taken && !load_use;
  assign bus.flush_execute        = !reset && taken && !load_use;

  always_ff @(posedge clock) begin
    if (reset) begin
      mem_alu    <= '0;
      mem_store  <= '0;
      mem_rd     <= '0;
      mem_funct3 <= '0;
      mem_src    <= 1'b0;
      mem_rd_we  <= 1'b0;
      mem_mem_we <= 1'b0;
    end else begin
      mem_alu    <= is_jump ? link : alu_result;
      mem_store  <= fwd_rs2;
      mem_rd     <= bus.rdAddr_execute;
      mem_funct3 <= bus.funct3_execute;
      mem_src    <= bus.rdSource_execute;
      mem_rd_we  <= bus.rdWriteEnable_execute && !load_use;
      mem_mem_we <= bus.memoryWriteEnable_execute && !load_use;
    end
  end

  assign bus.aluResult_memory         = mem_alu;
  assign bus.storeData_memory         = mem_store;
  assign bus.rdAddr_memory            = mem_rd;
  assign bus.funct3_memory            = mem_funct3;
  assign bus.rdSource_memory          = mem_src;
  assign bus.rdWriteEnable_memory     = mem_rd_we;
  assign bus.memoryWriteEnable_memory = mem_mem_we;

endmodule

`default_nettype wire

// File: tb/tb_jzjpcc_execute.sv
// tb_jzjpcc_execute: directed vectors with a scoreboard queue; a negedge monitor checks
// same-cycle control outputs and the memory-stage register one cycle later.
`default_nettype none

module tb_jzjpcc_execute;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  jzjpcc_execute_if #(.PC_MAX_B(31)) bus();

  jzjpcc_execute #(.PC_MAX_B(31)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus.slave)
  );

  typedef struct {
    logic        rst, rdwe, mwe, mod, src, br, jal, jalr, wbwe;
    logic [2:0]  op, f3;
    logic [1:0]  mux;
    logic [4:0]  rd, a1, a2, wbrd;
    logic [31:0] imm, pc, rs1, rs2, wbdata;
  } stim_t;

  typedef struct {
    logic        pc_we, flush, stall;
    logic [29:0] npc;
    bit          npc_care;
    bit          only_en;
    logic [31:0] alu, store;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic        src, rwe, mwe;
  } exp_t;

  exp_t q[$];
  exp_t pend;
  bit   have_pend = 0;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (have_pend) begin
      chk("rdWriteEnable_memory", 32'(bus.rdWriteEnable_memory), 32'(pend.rwe));
      chk("memoryWriteEnable_memory", 32'(bus.memoryWriteEnable_memory), 32'(pend.mwe));
      if (!pend.only_en) begin
        chk("aluResult_memory", bus.aluResult_memory, pend.alu);
        chk("storeData_memory", bus.storeData_memory, pend.store);
        chk("rdAddr_memory", 32'(bus.rdAddr_memory), 32'(pend.rd));
        chk("funct3_memory", 32'(bus.funct3_memory), 32'(pend.f3));
        chk("rdSource_memory", 32'(bus.rdSource_memory), 32'(pend.src));
      end
      have_pend = 0;
    end
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("pcCTWriteEnable", 32'(bus.pcCTWriteEnable), 32'(e.pc_we));
      chk("flush_execute", 32'(bus.flush_execute), 32'(e.flush));
      chk("stall_request", 32'(bus.stall_request), 32'(e.stall));
      if (e.npc_care)
        chk("controlTransferNewPC", 32'(bus.controlTransferNewPC), 32'(e.npc));
      pend = e;
      have_pend = 1;
    end
  end

  task automatic drive(input stim_t s, input exp_t e);
    @(posedge clk);
    #1;
    rst                           = s.rst;
    bus.rdWriteEnable_execute     = s.rdwe;
    bus.memoryWriteEnable_execute = s.mwe;
    bus.aluOperation_execute      = s.op;
    bus.aluMod_execute            = s.mod;
    bus.aluMuxMode_execute        = s.mux;
    bus.rdSource_execute          = s.src;
    bus.rdAddr_execute            = s.rd;
    bus.funct3_execute            = s.f3;
    bus.immediate_execute         = s.imm;
    bus.currentPC_execute         = s.pc[31:2];
    bus.rs1_execute               = s.rs1;
    bus.rs2_execute               = s.rs2;
    bus.rs1Addr_execute           = s.a1;
    bus.rs2Addr_execute           = s.a2;
    bus.branch_execute            = s.br;
    bus.jal_execute               = s.jal;
    bus.jalr_execute              = s.jalr;
    bus.rdWriteEnable_writeback   = s.wbwe;
    bus.rdAddr_writeback          = s.wbrd;
    bus.rdData_writeback          = s.wbdata;
    q.push_back(e);
  endtask

  stim_t s;
  exp_t  e;
  stim_t z_s;
  exp_t  z_e;

  initial begin
    z_s = '{default: '0};
    z_e = '{default: '0};
    s   = z_s;
    s.rst = 1'b1;
    drive(s, z_e);  // settles bus inputs before the first edge

    // Reset held two cycles with a taken beq presented.
    s = z_s; s.rst = 1; s.br = 1; s.pc = 32'h100; s.a1 = 1; s.a2 = 2;
    s.rs1 = 9; s.rs2 = 9; s.imm = 32'hFFFF_FFF8; s.rdwe = 1; s.rd = 3;
    e = z_e;
    drive(s, e);
    drive(s, e);

    // add x3,x1,x2: 7 + 0xFFFFFFFE
    s = z_s; s.rdwe = 1; s.rd = 3; s.a1 = 1; s.rs1 = 7; s.a2 = 2; s.rs2 = 32'hFFFF_FFFE;
    e = z_e; e.alu = 5; e.store = 32'hFFFF_FFFE; e.rd = 3; e.rwe = 1;
    drive(s, e);

    for (int k = 0; k < 2; k++) begin
      // addi x5,x0,0x10
      s = z_s; s.rdwe = 1; s.rd = 5; s.mux = 2'b11; s.imm = 32'h10;
      e = z_e; e.alu = 32'h10; e.rd = 5; e.rwe = 1;
      drive(s, e);
      // addi x6,x5,4 with stale rs1; second pass also offers writeback x5=0x99
      s = z_s; s.rdwe = 1; s.rd = 6; s.mux = 2'b01; s.a1 = 5; s.rs1 = 0; s.imm = 4;
      if (k == 1) begin s.wbwe = 1; s.wbrd = 5; s.wbdata = 32'h99; end
      e = z_e; e.alu = 32'h14; e.rd = 6; e.rwe = 1;
      drive(s, e);
    end

    // add x7,x8,x9 with x8 only available from writeback
    s = z_s; s.rdwe = 1; s.rd = 7; s.a1 = 8; s.rs1 = 1; s.a2 = 9; s.rs2 = 2;
    s.wbwe = 1; s.wbrd = 8; s.wbdata = 32'h99;
    e = z_e; e.alu = 32'h9B; e.store = 2; e.rd = 7; e.rwe = 1;
    drive(s, e);

    // beq taken, then bne not taken
    s = z_s; s.br = 1; s.pc = 32'h100; s.a1 = 1; s.rs1 = 9; s.a2 = 2; s.rs2 = 9;
    s.imm = 32'hFFFF_FFF8;
    e = z_e; e.pc_we = 1; e.flush = 1; e.npc = 30'h3E; e.npc_care = 1;
    e.alu = 32'h12; e.store = 9;
    drive(s, e);
    s.f3 = 3'b001;
    e.pc_we = 0; e.flush = 0; e.f3 = 3'b001;
    drive(s, e);

    // jalr x1, 0(x1) with rs1=0x2003 at PC 0x40
    s = z_s; s.jalr = 1; s.rdwe = 1; s.rd = 1; s.mux = 2'b01; s.a1 = 1;
    s.rs1 = 32'h2003; s.pc = 32'h40;
    e = z_e; e.pc_we = 1; e.flush = 1; e.npc = 30'h800; e.npc_care = 1;
    e.alu = 32'h44; e.rd = 1; e.rwe = 1;
    drive(s, e);

    // jal x1, +0x10 at PC 0x200
    s = z_s; s.jal = 1; s.rdwe = 1; s.rd = 1; s.mux = 2'b10; s.pc = 32'h200; s.imm = 32'h10;
    e = z_e; e.pc_we = 1; e.flush = 1; e.npc = 30'h84; e.npc_care = 1;
    e.alu = 32'h204; e.rd = 1; e.rwe = 1;
    drive(s, e);

    // blt -1 < 1 taken (ALU slt), then bltu not taken (ALU sltu)
    s = z_s; s.br = 1; s.f3 = 3'b100; s.op = 3'b010; s.pc = 32'h300; s.imm = 32'h20;
    s.a1 = 10; s.rs1 = 32'hFFFF_FFFF; s.a2 = 11; s.rs2 = 1;
    e = z_e; e.pc_we = 1; e.flush = 1; e.npc = 30'hC8; e.npc_care = 1;
    e.alu = 1; e.store = 1; e.f3 = 3'b100;
    drive(s, e);
    s.f3 = 3'b110; s.op = 3'b011;
    e.pc_we = 0; e.flush = 0; e.alu = 0; e.f3 = 3'b110;
    drive(s, e);

    // sra x12,x13,x14
    s = z_s; s.rdwe = 1; s.rd = 12; s.op = 3'b101; s.mod = 1;
    s.a1 = 13; s.rs1 = 32'h8000_0000; s.a2 = 14; s.rs2 = 4;
    e = z_e; e.alu = 32'hF800_0000; e.store = 4; e.rd = 12; e.rwe = 1;
    drive(s, e);

    // lw x4, 8(x2)
    s = z_s; s.rdwe = 1; s.src = 1; s.rd = 4; s.mux = 2'b01; s.f3 = 3'b010;
    s.a1 = 2; s.rs1 = 32'h1000; s.imm = 8; s.rs2 = 32'h77;
    e = z_e; e.alu = 32'h1008; e.rd = 4; e.f3 = 3'b010; e.src = 1; e.rwe = 1;
    drive(s, e);

    // dependent taken beq on x4: stall wins, bubble registered
    s = z_s; s.br = 1; s.pc = 32'h100; s.imm = 32'hFFFF_FFF8; s.rdwe = 1; s.mwe = 1;
    s.a1 = 1; s.rs1 = 9; s.a2 = 4; s.rs2 = 9;
    e = z_e; e.stall = 1; e.npc = 30'h3E; e.npc_care = 1; e.only_en = 1;
    drive(s, e);

    // load into x0, then an instruction reading x0: no stall, operands zero
    s = z_s; s.rdwe = 1; s.src = 1; s.rd = 0; s.mux = 2'b01; s.a1 = 2; s.rs1 = 32'h1000;
    e = z_e; e.alu = 32'h1000; e.src = 1; e.rwe = 1;
    drive(s, e);
    s = z_s; s.rdwe = 1; s.rd = 9; s.a1 = 0; s.rs1 = 32'h55; s.a2 = 0; s.rs2 = 32'h66;
    e = z_e; e.rd = 9; e.rwe = 1;
    drive(s, e);

    s = z_s;
    drive(s, z_e);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/jzjpcc_execute.md
Name: jzjpcc_execute

Overview:
- Consumer end of the decode-to-execute pipeline interface.
- Takes the fields the decode stage latches each cycle and computes the ALU/link result.
- Resolves branches and jumps, and drives the fetch-stage control-transfer inputs and the flush_execute hazard line back to decode.
- Registers its results into the execute-to-memory pipeline register, forwarding from memory and writeback stages.

Parameters:
PC_MAX_B, 31, MSB of the word-aligned PC; PC fields are [PC_MAX_B:2].

Ports:
clock  in  1  sole clock, rising edge
reset  in  1  synchronous, active-high
rdWriteEnable_execute  in  1  write rd (cleared by decode on flush)
memoryWriteEnable_execute  in  1  store (cleared by decode on flush)
aluOperation_execute  in  3  RV32I funct3-style ALU op
aluMod_execute  in  1  sub (op 000) / sra (op 101)
aluMuxMode_execute  in  2  operand select
rdSource_execute  in  1  0=ALU/link result, 1=load data
rdAddr_execute  in  5  destination register
funct3_execute  in  3  branch condition / memory width
immediate_execute  in  32  sign-extended immediate
currentPC_execute  in  PC_MAX_B-1  instruction PC [PC_MAX_B:2]
rs1_execute, rs2_execute  in  32 each  register-file values read in decode
rs1Addr_execute, rs2Addr_execute  in  5 each  source addresses (new interface fields)
branch_execute, jal_execute, jalr_execute  in  1 each  control-transfer class (new interface fields)
rdWriteEnable_writeback  in  1  writeback stage writes rd
rdAddr_writeback  in  5  writeback destination
rdData_writeback  in  32  writeback data
pcCTWriteEnable  out  1  fetch latches controlTransferNewPC
controlTransferNewPC  out  PC_MAX_B-1  redirect target
flush_execute  out  1  squash instruction entering execute
stall_request  out  1  load-use hazard detected
aluResult_memory  out  32  registered result / memory address
storeData_memory  out  32  registered forwarded rs2
rdAddr_memory  out  5
funct3_memory  out  3
rdSource_memory  out  1
rdWriteEnable_memory  out  1
memoryWriteEnable_memory  out  1

Behaviour:
- Valid instruction means rdWriteEnable_execute or memoryWriteEnable_execute or a control-transfer flag is set. A flushed bubble has all of these zero and produces no effect.
- Forwarding, combinational, per source:
  - If addr==0, the operand is 0.
  - Else if rdWriteEnable_memory && rdSource_memory==0 && rdAddr_memory==addr, use aluResult_memory.
  - Else if rdWriteEnable_writeback && rdAddr_writeback==addr, use rdData_writeback.
  - Else use the rs value. Memory-stage forwarding has priority over writeback.
- stall_request = rdWriteEnable_memory && rdSource_memory && rdAddr_memory!=0 && rdAddr_memory matches rs1Addr_execute or rs2Addr_execute. It is combinational; the hazard unit handles the response.
- Operand mux:
  - 00: fwdRs1 op fwdRs2
  - 01: fwdRs1 op imm
  - 10: {PC,2'b00} op imm
  - 11: 0 op imm
- ALU ops (aluMod applies to 000 and 101 only; register-register forms only):
  - 000 add/sub
  - 001 sll
  - 010 slt (signed)
  - 011 sltu
  - 100 xor
  - 101 srl/sra
  - 110 or
  - 111 and
  - Shift amount is operand B[4:0]. Arithmetic is 32-bit wraparound.
- Branch condition by funct3: 000 eq, 001 ne, 100 lt, 101 ge, 110 ltu, 111 geu; 010/011 never taken.
- Control transfer, combinational, same cycle:
  - Taken = jal | jalr | (branch & condition).
  - Target: jal/branch = {PC,00}+imm; jalr = (fwdRs1+imm) & ~1.
  - controlTransferNewPC = target[PC_MAX_B:2]; target bit 1 is ignored.
  - pcCTWriteEnable = flush_execute = taken.
- For jal/jalr the registered result is the link {PC,00}+4, zero-extended to 32 bits; otherwise it is the ALU result.
- Pipeline register: latency 1, all memory-stage outputs update on each rising edge.
- Reset, synchronous, with priority over everything:
  - rdWriteEnable_memory=0, memoryWriteEnable_memory=0.
  - rdSource_memory=0, aluResult_memory=0, storeData_memory=0, rdAddr_memory=0, funct3_memory=0.
- Reset gating of combinational outputs: pcCTWriteEnable, flush_execute and stall_request are forced to 0 while reset is high.
- When stall_request is high, the pipeline register loads a bubble (both enables 0) and pcCTWriteEnable is suppressed.
- Simultaneous stall and taken branch: the stall wins, and the branch resolves on the replay.
- Branch with rdAddr nonzero: rdWriteEnable is passed through as given, since decode never sets it for branches.

Decomposition:
- jzjpcc_pkg holds the aluMuxMode and aluOperation encodings, branch funct3 constants and the operand-mux enum.
- One sub-module: jzjpcc_alu (combinational, 32-bit, op + mod), shared with verification models.

Test Plan:
- Reset held 2 cycles with valid inputs → all memory-stage outputs 0 and pcCTWriteEnable=0 throughout.
- add x3,x1,x2 with rs1=7, rs2=0xFFFFFFFE, mux 00 → one cycle later aluResult_memory=5, rdAddr_memory=3, rdWriteEnable_memory=1.
- Back-to-back dependency: mem-stage rd=5 result=0x10, execute rs1Addr=5 (stale 0), op add imm=4 → aluResult_memory=0x14. The same case with writeback rd=5 data=0x99 present still gives 0x14 (memory-stage priority).
- beq with PC=0x100, fwdRs1=fwdRs2=9, imm=-8 → pcCTWriteEnable=1, flush_execute=1, controlTransferNewPC=0xF8>>2. With bne, both enables stay 0.
- jalr rs1=0x2003, imm=0, rd=1, PC=0x40 → target 0x2002 (bit 0 cleared, bit 1 ignored, NewPC=0x800), aluResult_memory=0x44.
- Load-use: mem-stage rdSource=1 rd=4, execute rs2Addr=4 → stall_request=1, the next register value is a bubble and any branch is suppressed. With rd=0, stall_request=0.
